// File: rtl/kernel_mem_ctrl.sv
// kernel_mem_ctrl: sequencing controller for the two-half kernel memory block.
// Fills the block from 16-complex cachelines. Each line becomes two 8-complex writes at the
// same address: lower half first, then upper half. On command it sweeps the read port over
// every loaded line and flags read data valid one cycle later, matching the RAM's read latency.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   load_start, num_lines    load command and line count (1..2**ADDR_WIDTH), sampled in idle
//   line_valid/line_ready    cacheline handshake, line_data carries 16 complex values
//   mem_we, mem_select       write enable and half select (0 = complex 0..7, 1 = complex 8..15)
//   mem_write_address        write address, the same for both halves of a line
//   mem_data_in              8 complex values for the selected half
//   read_start               read-sweep command, sampled in idle
//   mem_read_address         read address, steps once per cycle during a sweep
//   rd_valid, rd_last        read data valid / final beat of the sweep
//   busy, load_done, cmd_err status, load-complete pulse, rejected-load pulse
module kernel_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   num_lines,
  input  logic                  line_valid,
  output logic                  line_ready,
  input  logic [1023:0]         line_data,
  output logic                  mem_we,
  output logic                  mem_select,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [511:0]          mem_data_in,
  input  logic                  read_start,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  load_done,
  output logic                  cmd_err
);

  typedef enum logic [1:0] {StIdle, StLoadLo, StLoadHi, StRead} state_e;

  localparam logic [ADDR_WIDTH:0]   MaxLines = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LenOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   loaded_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [511:0]          hold_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  load_done_q;
  logic                  cmd_err_q;

  logic num_ok;
  logic wr_last;
  logic rd_at_end;

  assign num_ok    = (num_lines != '0) && (num_lines <= MaxLines);
  // Addresses are compared one bit wider so len = 2**ADDR_WIDTH ends at the top address.
  assign wr_last   = ({1'b0, wr_addr_q} == (len_q - LenOne));
  assign rd_at_end = ({1'b0, rd_addr_q} == (loaded_q - LenOne));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      loaded_q    <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      hold_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      load_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_valid_q  <= (state_q == StRead);
      rd_last_q   <= (state_q == StRead) && rd_at_end;
      unique case (state_q)
        StIdle: begin
          // A load always wins over a simultaneous read request.
          if (load_start) begin
            if (num_ok) begin
              len_q     <= num_lines;
              loaded_q  <= '0;
              wr_addr_q <= '0;
              state_q   <= StLoadLo;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end else if (read_start && (loaded_q != '0)) begin
            rd_addr_q <= '0;
            state_q   <= StRead;
          end
        end
        StLoadLo: begin
          if (line_valid) begin
            hold_q  <= line_data[1023:512];
            state_q <= StLoadHi;
          end
        end
        StLoadHi: begin
          if (wr_last) begin
            loaded_q    <= len_q;
            load_done_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            wr_addr_q <= wr_addr_q + AddrOne;
            state_q   <= StLoadLo;
          end
        end
        StRead: begin
          // rd_addr holds its final value on exit.
          if (rd_at_end) begin
            state_q <= StIdle;
          end else begin
            rd_addr_q <= rd_addr_q + AddrOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign line_ready        = (state_q == StLoadLo);
  assign mem_we            = ((state_q == StLoadLo) && line_valid) || (state_q == StLoadHi);
  assign mem_select        = (state_q == StLoadHi);
  assign mem_write_address = wr_addr_q;
  assign mem_read_address  = rd_addr_q;
  assign busy              = (state_q != StIdle);
  assign rd_valid          = rd_valid_q;
  assign rd_last           = rd_last_q;
  assign load_done         = load_done_q;
  assign cmd_err           = cmd_err_q;

  always_comb begin
    mem_data_in = '0;
    unique case (state_q)
      StLoadLo: mem_data_in = line_data[511:0];
      StLoadHi: mem_data_in = hold_q;
      default:  mem_data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_kernel_mem_ctrl.sv
// Bench for kernel_mem_ctrl: random cachelines are loaded and read back through a behavioural
// two-half RAM; writes and reads are checked against an expected per-line image.
module tb_kernel_mem_ctrl;

  localparam int AW    = 9;
  localparam int Depth = 1 << AW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_start = 1'b0;
  logic [AW:0]     num_lines = '0;
  logic            line_valid = 1'b0;
  logic            line_ready;
  logic [1023:0]   line_data = '0;
  logic            mem_we;
  logic            mem_select;
  logic [AW-1:0]   mem_write_address;
  logic [511:0]    mem_data_in;
  logic            read_start = 1'b0;
  logic [AW-1:0]   mem_read_address;
  logic            rd_valid;
  logic            rd_last;
  logic            busy;
  logic            load_done;
  logic            cmd_err;

  int total = 0;
  int bad   = 0;

  logic [1023:0] lines   [Depth];
  logic [1023:0] exp_img [Depth];
  logic [1023:0] ram     [Depth];
  logic [1023:0] rd_q;

  always #5 clk = ~clk;

  kernel_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .load_start        (load_start),
    .num_lines         (num_lines),
    .line_valid        (line_valid),
    .line_ready        (line_ready),
    .line_data         (line_data),
    .mem_we            (mem_we),
    .mem_select        (mem_select),
    .mem_write_address (mem_write_address),
    .mem_data_in       (mem_data_in),
    .read_start        (read_start),
    .mem_read_address  (mem_read_address),
    .rd_valid          (rd_valid),
    .rd_last           (rd_last),
    .busy              (busy),
    .load_done         (load_done),
    .cmd_err           (cmd_err)
  );

  // Two-half kernel memory with one-cycle read latency; never cleared by reset.
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_select) ram[mem_write_address][1023:512] <= mem_data_in;
      else            ram[mem_write_address][511:0]    <= mem_data_in;
    end
    rd_q <= ram[mem_read_address];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wide compare; only the low 64 bits are printed to keep lines short.
  task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed(lo64)=%0h expected(lo64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, line_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_sel"}, mem_select, 0);
    chk({tag, "_waddr"}, mem_write_address, 0);
    chk_wide({tag, "_wdata"}, {512'b0, mem_data_in}, '0);
    chk({tag, "_raddr"}, mem_read_address, 0);
    chk({tag, "_rvalid"}, rd_valid, 0);
    chk({tag, "_rlast"}, rd_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, cmd_err, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load n lines; gap is the percent chance line_valid is dropped in a cycle.
  task automatic do_load(input int n, input int gap, input bit regen, input bit with_read);
    int wi;
    int li;
    int cyc;
    int first;
    int last;
    int early;
    bit hs;
    logic [511:0] exp_half;
    if (regen) begin
      for (int i = 0; i < n; i++)
        for (int w = 0; w < 32; w++) lines[i][w*32 +: 32] = $urandom;
    end
    load_start = 1'b1;
    num_lines  = (AW+1)'(n);
    read_start = with_read;
    @(negedge clk);
    chk("idle_before_load", busy, 0);
    step();
    load_start = 1'b0;
    read_start = 1'b0;
    wi = 0; li = 0; cyc = 0; first = -1; last = -1; early = 0;
    while (wi < 2 * n && cyc < 8 * n + 50) begin
      line_valid = (li < n) && ($urandom_range(0, 99) >= gap);
      if (li < n) line_data = lines[li];
      read_start = ($urandom_range(0, 3) == 0);  // must be ignored while loading
      @(negedge clk);
      if (cyc == 0) begin
        chk("load_busy", busy, 1);
        chk("load_ready", line_ready, 1);
      end
      if (line_ready && !line_valid) chk("no_we_stall", mem_we, 0);
      if (load_done || cmd_err) early++;
      if (mem_we) begin
        exp_half = (wi % 2 == 1) ? lines[wi/2][1023:512] : lines[wi/2][511:0];
        chk("wr_addr", mem_write_address, wi / 2);
        chk("wr_sel", mem_select, wi % 2);
        chk_wide("wr_data", {512'b0, mem_data_in}, {512'b0, exp_half});
        if (first < 0) first = cyc;
        last = cyc;
        wi++;
      end
      hs = line_ready && line_valid;
      step();
      if (hs) li++;
      cyc++;
    end
    line_valid = 1'b0;
    read_start = 1'b0;
    chk("load_all_writes", wi, 2 * n);
    chk("no_early_pulse", early, 0);
    if (gap == 0) chk("load_cycles", last - first + 1, 2 * n);
    @(negedge clk);
    chk("load_done_pulse", load_done, 1);
    chk("idle_after_load", busy, 0);
    step();
    @(negedge clk);
    chk("load_done_once", load_done, 0);
    step();
    for (int i = 0; i < n; i++) exp_img[i] = lines[i];
  endtask

  task automatic do_read(input int n);
    read_start = 1'b1;
    @(negedge clk);
    chk("idle_before_read", busy, 0);
    step();
    read_start = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      if (k < n) begin
        chk("rd_addr", mem_read_address, k);
        chk("rd_busy", busy, 1);
      end else begin
        chk("rd_idle", busy, 0);
      end
      chk("rd_valid", rd_valid, (k >= 1 && k <= n));
      chk("rd_last", rd_last, (k == n));
      if (k >= 1 && k <= n) chk_wide("rd_data", rd_q, exp_img[k-1]);
      if (k == n) chk("rd_end_addr", mem_read_address, n - 1);
      step();
    end
  endtask

  initial begin
    int bad_n [2];
    int rn;
    bit found;
    bad_n[0] = 0;
    bad_n[1] = 513;

    // Reset with noisy inputs present.
    line_data = {32{$urandom}};
    line_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_init");
    line_valid = 1'b0;
    step();
    reset = 1'b0;

    // Read with nothing loaded is ignored without error.
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    @(negedge clk);
    chk("read_empty_busy", busy, 0);
    chk("read_empty_err", cmd_err, 0);
    step();

    // Out-of-range line counts are rejected.
    for (int i = 0; i < 2; i++) begin
      load_start = 1'b1;
      num_lines  = (AW+1)'(bad_n[i]);
      @(negedge clk);
      chk("err_before", cmd_err, 0);
      step();
      load_start = 1'b0;
      @(negedge clk);
      chk("err_pulse", cmd_err, 1);
      chk("err_busy", busy, 0);
      step();
      @(negedge clk);
      chk("err_once", cmd_err, 0);
      step();
    end

    // Back-to-back load, then gapped load of the same lines must give the same image.
    do_load(4, 0, 1'b1, 1'b0);
    do_read(4);
    do_load(4, 50, 1'b0, 1'b0);
    do_read(4);

    // Load and read together: the load runs.
    do_load(3, 0, 1'b1, 1'b1);
    do_read(3);

    // Random length, gapped.
    rn = $urandom_range(1, 20);
    do_load(rn, 30, 1'b1, 1'b0);
    do_read(rn);

    // Reset during the upper-half write of line 5.
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 32; w++) lines[i][w*32 +: 32] = $urandom;
    load_start = 1'b1;
    num_lines  = (AW+1)'(8);
    step();
    load_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      line_valid = 1'b1;
      line_data  = lines[c/2];
      @(negedge clk);
      if (mem_select && mem_write_address == AW'(5)) found = 1'b1;
      else step();
    end
    chk("reset_reach_hi5", found, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_async");
    line_valid = 1'b0;
    step();
    reset = 1'b0;
    read_start = 1'b1;
    step();
    read_start = 1'b0;
    @(negedge clk);
    chk("read_after_partial_busy", busy, 0);
    step();
    @(negedge clk);
    chk("read_after_partial_valid", rd_valid, 0);
    step();

    // Full depth.
    do_load(Depth, 0, 1'b1, 1'b0);
    do_read(Depth);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
